// File: rtl/ssram_1r1w_pipe.sv
// Synchronous 1R1W SRAM with byte-enable writes and a valid/ready read pipeline.
// Optional zero-initialisation sequence after reset is compiled in with SSRAM_INIT_ZERO_EN.
module ssram_1r1w_pipe #(
  parameter int NUM_WORDS  = 1024,
  parameter int DATA_LEN   = 64,
  parameter int RD_LATENCY = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           wr_valid_i,
  output logic                           wr_ready_o,
  input  logic [$clog2(NUM_WORDS)-1:0]   wr_addr_i,
  input  logic [(DATA_LEN+7)/8-1:0]      wr_be_i,
  input  logic [DATA_LEN-1:0]            wr_data_i,
  input  logic                           rd_req_valid_i,
  output logic                           rd_req_ready_o,
  input  logic [$clog2(NUM_WORDS)-1:0]   rd_addr_i,
  output logic                           rd_rsp_valid_o,
  input  logic                           rd_rsp_ready_i,
  output logic [DATA_LEN-1:0]            rd_rsp_data_o
);

  localparam int AW = $clog2(NUM_WORDS);

  logic [DATA_LEN-1:0] mem_q [NUM_WORDS];

  logic [DATA_LEN-1:0] be_mask;
  logic [DATA_LEN-1:0] wr_merged;
  logic [DATA_LEN-1:0] rd_word;
  logic [DATA_LEN-1:0] mem_wdata;
  logic [AW-1:0]       mem_waddr;
  logic [AW-1:0]       init_addr;
  logic                mem_we;
  logic                in_init;
  logic                wr_fire;
  logic                rd_fire;
  logic                stall;

  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [DATA_LEN-1:0]   dat_q [RD_LATENCY];
  logic [DATA_LEN-1:0]   dat_d [RD_LATENCY];

`ifdef SSRAM_INIT_ZERO_EN
  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] init_cnt_q, init_cnt_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // One zero word per cycle; leave INIT right after the top address is written.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    in_init    = (state_q == ST_INIT);
    if (in_init) begin
      init_cnt_d = init_cnt_q + AW'(1);
      if (init_cnt_q == AW'(NUM_WORDS - 1)) begin
        state_d = ST_RUN;
      end
    end
  end

  assign init_addr = init_cnt_q;
`else
  assign in_init   = 1'b0;
  assign init_addr = '0;
`endif

  // Expand byte enables to a bit mask; the top lane is naturally truncated to DATA_LEN.
  always_comb begin
    be_mask = '0;
    for (int i = 0; i < DATA_LEN; i++) begin
      be_mask[i] = wr_be_i[i/8];
    end
  end

  assign stall          = vld_q[RD_LATENCY-1] & ~rd_rsp_ready_i;
  assign wr_ready_o     = ~in_init;
  assign rd_req_ready_o = ~in_init & ~stall;
  assign wr_fire        = wr_valid_i & wr_ready_o;
  assign rd_fire        = rd_req_valid_i & rd_req_ready_o;

  // Write-first: a same-address read sees the merged word being written this edge.
  always_comb begin
    wr_merged = (mem_q[wr_addr_i] & ~be_mask) | (wr_data_i & be_mask);
    rd_word   = (wr_fire && (wr_addr_i == rd_addr_i)) ? wr_merged : mem_q[rd_addr_i];
    mem_we    = wr_fire | in_init;
    mem_waddr = in_init ? init_addr : wr_addr_i;
    mem_wdata = in_init ? '0 : wr_merged;
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Whole pipeline freezes on stall, otherwise it shifts and bubbles move along.
  always_comb begin
    vld_d = vld_q;
    for (int i = 0; i < RD_LATENCY; i++) begin
      dat_d[i] = dat_q[i];
    end
    if (!stall) begin
      vld_d[0] = rd_fire;
      if (rd_fire) begin
        dat_d[0] = rd_word;
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < RD_LATENCY; i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  assign rd_rsp_valid_o = vld_q[RD_LATENCY-1];
  assign rd_rsp_data_o  = dat_q[RD_LATENCY-1];

endmodule

// File: tb/tb_ssram_1r1w_pipe.sv
// Self-checking bench for ssram_1r1w_pipe: directed plan steps plus randomized traffic
// compared against a queue-based reference model (honours SSRAM_INIT_ZERO_EN if defined).
module tb_ssram_1r1w_pipe;

  localparam int NUM_WORDS  = 16;
  localparam int DATA_LEN   = 64;
  localparam int RD_LATENCY = 3;
  localparam int AW         = $clog2(NUM_WORDS);

  logic                clk_i = 1'b0;
  logic                rst_n_i = 1'b0;
  logic                wr_valid_i = 1'b0;
  logic                wr_ready_o;
  logic [AW-1:0]       wr_addr_i = '0;
  logic [7:0]          wr_be_i = '0;
  logic [DATA_LEN-1:0] wr_data_i = '0;
  logic                rd_req_valid_i = 1'b0;
  logic                rd_req_ready_o;
  logic [AW-1:0]       rd_addr_i = '0;
  logic                rd_rsp_valid_o;
  logic                rd_rsp_ready_i = 1'b1;
  logic [DATA_LEN-1:0] rd_rsp_data_o;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [DATA_LEN-1:0] data;
    int                  age;
  } infl_t;

  logic [DATA_LEN-1:0] mem_m [NUM_WORDS];
  infl_t               pend[$];
  int                  init_left = 0;
  bit                  m_rd_fire = 1'b0;

  ssram_1r1w_pipe #(
    .NUM_WORDS (NUM_WORDS),
    .DATA_LEN  (DATA_LEN),
    .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .wr_valid_i    (wr_valid_i),
    .wr_ready_o    (wr_ready_o),
    .wr_addr_i     (wr_addr_i),
    .wr_be_i       (wr_be_i),
    .wr_data_i     (wr_data_i),
    .rd_req_valid_i(rd_req_valid_i),
    .rd_req_ready_o(rd_req_ready_o),
    .rd_addr_i     (rd_addr_i),
    .rd_rsp_valid_o(rd_rsp_valid_o),
    .rd_rsp_ready_i(rd_rsp_ready_i),
    .rd_rsp_data_o (rd_rsp_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [DATA_LEN-1:0] obs,
                             input logic [DATA_LEN-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: each accepted read ages by one per unstalled edge and is
  // presented once its age reaches the read latency.
  task automatic modelEdge();
    bit                  init_m;
    bit                  stall_m;
    bit                  wf;
    logic [DATA_LEN-1:0] merged;
    logic [DATA_LEN-1:0] rdata;
    init_m  = (init_left > 0);
    stall_m = (pend.size() > 0) && (pend[0].age == RD_LATENCY) && !rd_rsp_ready_i;
    wf        = wr_valid_i && !init_m;
    m_rd_fire = rd_req_valid_i && !stall_m && !init_m;
    merged = mem_m[wr_addr_i];
    for (int b = 0; b < 8; b++) begin
      if (wr_be_i[b]) merged[8*b +: 8] = wr_data_i[8*b +: 8];
    end
    rdata = (wf && wr_addr_i == rd_addr_i) ? merged : mem_m[rd_addr_i];
    if (!stall_m) begin
      if (pend.size() > 0 && pend[0].age == RD_LATENCY) void'(pend.pop_front());
      foreach (pend[i]) pend[i].age++;
      if (m_rd_fire) pend.push_back('{data: rdata, age: 1});
    end
    if (wf) mem_m[wr_addr_i] = merged;
    if (init_m) begin
      mem_m[NUM_WORDS - init_left] = '0;
      init_left--;
    end
  endtask

  task automatic applyStimulus(input bit wv, input logic [AW-1:0] wa, input logic [7:0] be,
                               input logic [DATA_LEN-1:0] wd, input bit rv,
                               input logic [AW-1:0] ra, input bit rr);
    bit exp_valid;
    bit exp_run;
    @(negedge clk_i);
    wr_valid_i     = wv;
    wr_addr_i      = wa;
    wr_be_i        = be;
    wr_data_i      = wd;
    rd_req_valid_i = rv;
    rd_addr_i      = ra;
    rd_rsp_ready_i = rr;
    #1;
    exp_valid = (pend.size() > 0) && (pend[0].age == RD_LATENCY);
    exp_run   = (init_left == 0);
    checkOutput("wr_ready", DATA_LEN'(wr_ready_o), DATA_LEN'(exp_run));
    checkOutput("rd_req_ready", DATA_LEN'(rd_req_ready_o),
                DATA_LEN'(exp_run && !(exp_valid && !rr)));
    checkOutput("rsp_valid", DATA_LEN'(rd_rsp_valid_o), DATA_LEN'(exp_valid));
    if (exp_valid) checkOutput("rsp_data", rd_rsp_data_o, pend[0].data);
    @(posedge clk_i);
    modelEdge();
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, rr);
  endtask

  task automatic doReset();
    @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    checkOutput("reset_rsp_valid", DATA_LEN'(rd_rsp_valid_o), '0);
    checkOutput("reset_rsp_data", rd_rsp_data_o, '0);
    pend.delete();
`ifdef SSRAM_INIT_ZERO_EN
    init_left = NUM_WORDS;
`endif
    wr_valid_i     = 1'b0;
    rd_req_valid_i = 1'b0;
    rd_rsp_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i);
    modelEdge();
  endtask

  initial begin
    int idx;
    int cyc;
    for (int a = 0; a < NUM_WORDS; a++) mem_m[a] = 'x;

    $display("[TB] reset and start-up");
    doReset();
`ifdef SSRAM_INIT_ZERO_EN
    for (int i = 0; i < NUM_WORDS && init_left > 0; i++) idle(1, 1'b1);
    for (int a = 0; a < NUM_WORDS; a++) applyStimulus(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b1);
    idle(RD_LATENCY + 1, 1'b1);
`endif

    for (int a = 0; a < NUM_WORDS; a++)
      applyStimulus(1'b1, AW'(a), 8'hFF, {$urandom, $urandom}, 1'b0, '0, 1'b1);

    $display("[TB] full write then read with latency check");
    applyStimulus(1'b1, AW'(5), 8'hFF, 64'hDEADBEEF_01234567, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, AW'(5), 1'b1);
    idle(RD_LATENCY + 1, 1'b1);

    $display("[TB] partial byte-enable write");
    applyStimulus(1'b1, AW'(3), 8'hFF, 64'h1111111111111111, 1'b0, '0, 1'b1);
    applyStimulus(1'b1, AW'(3), 8'h0F, 64'hAAAAAAAAAAAAAAAA, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, AW'(3), 1'b1);
    idle(RD_LATENCY + 1, 1'b1);

    $display("[TB] read-during-write");
    applyStimulus(1'b1, AW'(7), 8'hFF, 64'hFF00, 1'b0, '0, 1'b1);
    applyStimulus(1'b1, AW'(7), 8'h01, 64'h55, 1'b1, AW'(7), 1'b1);
    applyStimulus(1'b1, AW'(8), 8'hFF, 64'h0123456789ABCDEF, 1'b1, AW'(9), 1'b1);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, AW'(8), 1'b1);
    idle(RD_LATENCY + 1, 1'b1);

    $display("[TB] back-to-back reads with mid-stream stall");
    idx = 0;
    cyc = 0;
    while ((idx < 6 || pend.size() > 0) && cyc < 40) begin
      applyStimulus(1'b0, '0, '0, '0, idx < 6, AW'(idx), !(cyc >= 4 && cyc < 8));
      if (m_rd_fire) idx++;
      cyc++;
    end
    checkOutput("stall_stream_done", DATA_LEN'(idx), DATA_LEN'(6));

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 1) == 1, AW'($urandom_range(0, NUM_WORDS - 1)),
                    8'($urandom), {$urandom, $urandom}, $urandom_range(0, 3) != 0,
                    AW'($urandom_range(0, NUM_WORDS - 1)), $urandom_range(0, 3) != 0);
    end
    idle(RD_LATENCY + 2, 1'b1);

    $display("[TB] reset with reads in flight");
    applyStimulus(1'b0, '0, '0, '0, 1'b1, AW'(1), 1'b1);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, AW'(2), 1'b1);
    doReset();
    idle(NUM_WORDS + RD_LATENCY + 2, 1'b1);
    applyStimulus(1'b0, '0, '0, '0, 1'b1, AW'(5), 1'b1);
    idle(RD_LATENCY + 1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ssram_1r1w_pipe.md
Name: ssram_1r1w_pipe

Overview:
Parametrised successor of the team's single-port synchronous SRAM model. It has separate, simultaneous write and read ports, each with its own address. Byte enables allow partial writes. The read path has a configurable latency and valid/ready backpressure. It is used as a behavioural memory for caches and the testbench memory wherever a read and a write must proceed in the same cycle.

Parameters:
NUM_WORDS, 1024, memory depth in words; power of 2, >= 2
DATA_LEN, 64, word width in bits; >= 8, need not be a multiple of 8
RD_LATENCY, 1, cycles from read request acceptance to response valid; legal range 1..4

Ports:
clk_i  in  1  main clock, rising edge
rst_n_i  in  1  asynchronous, active-low reset
wr_valid_i  in  1  write request valid
wr_ready_o  out  1  write request ready
wr_addr_i  in  $clog2(NUM_WORDS)  write word address
wr_be_i  in  (DATA_LEN+7)/8  byte enables; bit N selects byte N (little endian, byte 0 = LSB)
wr_data_i  in  DATA_LEN  write data
rd_req_valid_i  in  1  read request valid
rd_req_ready_o  out  1  read request ready
rd_addr_i  in  $clog2(NUM_WORDS)  read word address
rd_rsp_valid_o  out  1  read response valid
rd_rsp_ready_i  in  1  read response ready
rd_rsp_data_o  out  DATA_LEN  read response data

Behaviour:
- Reset values: rd_rsp_valid_o=0, rd_rsp_data_o=0, all pipeline valid bits=0. Memory contents are not reset.
- Write port:
  - A write fires when wr_valid_i && wr_ready_o.
  - On the firing edge, only enabled byte lanes are updated.
  - The last lane covers DATA_LEN-8*((DATA_LEN+7)/8-1) bits.
  - wr_ready_o=1 whenever not in init (see Optional Feature).
- Read pipeline:
  - RD_LATENCY stages, each holding a valid bit and a data register.
  - A request fires when rd_req_valid_i && rd_req_ready_o.
  - The array is read on the firing edge into stage 1.
  - stall = last-stage valid && !rd_rsp_ready_i.
  - rd_req_ready_o = !stall (and not in init).
  - On stall, every stage holds. Otherwise all stages shift by one, and bubbles propagate.
  - rd_rsp_valid_o and rd_rsp_data_o are driven from the last stage.
  - Back-to-back requests with rd_rsp_ready_i=1 give one response per cycle, in order, with no loss or duplication.
- Read-during-write, same address, same edge: write-first.
  - Enabled lanes return wr_data_i; disabled lanes return the old content.
  - Different addresses are independent.
- Data captured into the pipeline is a snapshot. Later writes to the same address do not alter responses already in flight.
- Reads of never-written words return X; no X-masking is done.
- Reset asserted mid-operation: in-flight responses are discarded immediately (async clear of valid bits). The array keeps its contents unless the init feature is compiled in.
- Addresses are exactly $clog2(NUM_WORDS) bits, so no out-of-range handling is needed.

Optional Feature:
Macro SSRAM_INIT_ZERO_EN.
- With it:
  - A two-state FSM, INIT and RUN, entered as INIT on reset.
  - INIT writes zero to address 0, 1, ... NUM_WORDS-1, one word per cycle, using an internal counter.
  - wr_ready_o=0 and rd_req_ready_o=0 throughout INIT.
  - After the NUM_WORDS-1 write, the FSM moves to RUN and both readies follow the rules above.
  - Init lasts exactly NUM_WORDS cycles after reset release.
  - Reset during INIT restarts the counter from 0.
- Without it: no FSM; the block is in RUN from the first edge after reset release, and the array is uninitialised.

Test Plan:
1. RD_LATENCY=2, write 0xDEADBEEF_01234567 to addr 5 with be=0xFF, read addr 5 next cycle -> rd_rsp_valid_o high exactly 2 cycles after acceptance, data 0xDEADBEEF_01234567.
2. addr 3 holds 0x1111111111111111; write 0xAAAAAAAAAAAAAAAA with be=0x0F -> readback 0x11111111AAAAAAAA.
3. Same-edge write 0x55 be=0x01 and read to addr 7 (old 0xFF00) -> response 0xFF55; different-address pair returns old data.
4. RD_LATENCY=3, issue reads to addr 0..5 back-to-back, hold rd_rsp_ready_i=0 for 4 cycles mid-stream -> rd_req_ready_o low while stalled; all 6 responses delivered in order, each once.
5. Assert rst_n_i with 2 reads in flight -> rd_rsp_valid_o=0 immediately; no stale response after release.
6. With SSRAM_INIT_ZERO_EN, NUM_WORDS=16 -> readies low for 16 cycles after reset release; all reads then return 0.
